// File: rtl/uart_tx_pkg.sv
// Shared definitions for the pull-mode UART transmitter: FSM state encoding
// and a constant-width helper.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_buf.sv
// Small circular queue between the upstream FIFO and the transmitter, plus the
// registered pull credit that keeps outstanding requests from overflowing it.
module uart_tx_buf
  import uart_tx_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic          push,
  input  logic [BW-1:0] din,
  input  logic          pop,
  output logic [BW-1:0] dout,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          pull
);

  logic [BW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          p1;
  logic          p2;
  logic          full;
  logic [AW+1:0] credit_sum;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rptr[AW-1:0]];

  // Words already buffered plus every pull whose reply may still arrive.
  assign credit_sum = (AW+2)'(count) + (AW+2)'(p1) + (AW+2)'(p2) + (AW+2)'(pull);

  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      pull <= 1'b0;
      p1   <= 1'b0;
      p2   <= 1'b0;
    end else begin
      if (push) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          wptr <= wptr + (AW+1)'(1);
        end
      end
      if (pop && (count != '0)) begin
        rptr <= rptr + (AW+1)'(1);
      end
      p1   <= pull;
      p2   <= p1;
      pull <= (credit_sum < (AW+2)'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_pull.sv
// UART transmitter that pulls words from an upstream FIFO, buffers them locally
// and sends each as start bit, BW data bits LSB first, and one stop bit.
module uart_tx_pull
  import uart_tx_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RSTX,
  output logic          DIPULL,
  input  logic          DIPUSH,
  input  logic [BW-1:0] DIN,
  output logic          TXD,
  output logic          BUSY,
  output logic          OVF
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DIV);
  localparam int IW = (clog2(BW) > 0) ? clog2(BW) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] bitidx;
  logic [BW-1:0] shreg;
  logic [BW-1:0] head;
  logic [AW:0]   count;
  logic          empty;
  logic          bit_end;
  logic          pop;

  uart_tx_buf #(
    .BW    (BW),
    .DEPTH (DEPTH)
  ) u_buf (
    .CLK   (CLK),
    .RSTX  (RSTX),
    .push  (DIPUSH),
    .din   (DIN),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .ovf   (OVF),
    .pull  (DIPULL)
  );

  assign empty   = (count == '0);
  assign bit_end = (cnt == CW'(DIV - 1));

  // The head word is taken either from idle or at the last stop-bit cycle,
  // which lets consecutive frames run with no gap.
  assign pop = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      TXD    <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      BUSY <= (state != ST_IDLE) || !empty;
      cnt  <= bit_end ? '0 : cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          TXD <= 1'b1;
          cnt <= '0;
          if (pop) begin
            shreg <= head;
            state <= ST_START;
            TXD   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state  <= ST_DATA;
            bitidx <= '0;
            TXD    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bitidx == IW'(BW - 1)) begin
              state <= ST_STOP;
              TXD   <= 1'b1;
            end else begin
              bitidx <= bitidx + IW'(1);
              shreg  <= shreg >> 1;
              TXD    <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg <= head;
              state <= ST_START;
              TXD   <= 1'b0;
            end else begin
              state <= ST_IDLE;
              TXD   <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          TXD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_pull.sv
// Self-checking bench for uart_tx_pull: an emulated upstream FIFO feeds the DUT
// and a queue-based reference predicts TXD, DIPULL, BUSY and OVF every cycle.
module tb_uart_tx_pull;

  localparam int BW    = 8;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (BW + 2) * DIV;

  logic          CLK = 1'b0;
  logic          RSTX = 1'b0;
  logic          DIPUSH = 1'b0;
  logic [BW-1:0] DIN = '0;
  logic          DIPULL;
  logic          TXD;
  logic          BUSY;
  logic          OVF;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] m_q[$];
  bit            m_active;
  logic [BW-1:0] m_byte;
  int            m_pos;
  bit            m_busy;
  bit            m_ovf;
  bit            m_pull;
  bit            m_p1;
  bit            m_p2;

  logic [BW-1:0] up_q[$];
  bit            up_d1;
  bit            up_d2;

  uart_tx_pull #(
    .BW    (BW),
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .CLK    (CLK),
    .RSTX   (RSTX),
    .DIPULL (DIPULL),
    .DIPUSH (DIPUSH),
    .DIN    (DIN),
    .TXD    (TXD),
    .BUSY   (BUSY),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level at the current position within the frame being sent.
  function automatic bit exp_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= BW) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    up_q.delete();
    m_active = 1'b0;
    m_byte   = '0;
    m_pos    = 0;
    m_busy   = 1'b0;
    m_ovf    = 1'b0;
    m_pull   = 1'b0;
    m_p1     = 1'b0;
    m_p2     = 1'b0;
    up_d1    = 1'b0;
    up_d2    = 1'b0;
  endtask

  task automatic model_step(input bit push, input logic [BW-1:0] d);
    int qs;
    bit pop;
    bit busy_n;
    bit pull_n;
    qs     = m_q.size();
    pop    = 1'b0;
    busy_n = m_active || (qs != 0);
    pull_n = (qs + int'(m_p1) + int'(m_p2) + int'(m_pull)) < DEPTH;
    if (!m_active) begin
      if (qs != 0) pop = 1'b1;
    end else if (m_pos == FRAME - 1) begin
      if (qs != 0) pop = 1'b1;
      else m_active = 1'b0;
    end else begin
      m_pos = m_pos + 1;
    end
    if (pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (push) begin
      if (qs == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
    m_busy = busy_n;
    m_p2   = m_p1;
    m_p1   = m_pull;
    m_pull = pull_n;
  endtask

  // One clock: check outputs, drive the upstream reply (or a forced push), advance.
  task automatic applyStimulus(input bit force_en, input bit force_push, input logic [BW-1:0] force_d);
    bit            push;
    logic [BW-1:0] d;
    checkOutput("txd", 32'(TXD), 32'(exp_txd()));
    checkOutput("dipull", 32'(DIPULL), 32'(m_pull));
    checkOutput("busy", 32'(BUSY), 32'(m_busy));
    checkOutput("ovf", 32'(OVF), 32'(m_ovf));
    push = 1'b0;
    d    = '0;
    if (force_en) begin
      push = force_push;
      d    = force_d;
    end else if (up_d2 && (up_q.size() != 0)) begin
      push = 1'b1;
      d    = up_q.pop_front();
    end
    up_d2  = up_d1;
    up_d1  = DIPULL;
    DIPUSH = push;
    DIN    = push ? d : BW'($urandom);
    @(posedge CLK);
    #1;
    model_step(push, d);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    RSTX   = 1'b0;
    DIPUSH = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RSTX = 1'b1;
  endtask

  initial begin
    do_reset();

    $display("[TB] idle after reset");
    run_cycles(12);

    $display("[TB] single frame 0x55");
    up_q.push_back(8'h55);
    run_cycles(FRAME + 10);

    $display("[TB] six words back to back");
    up_q.push_back(8'h00);
    up_q.push_back(8'hFF);
    up_q.push_back(8'hA5);
    up_q.push_back(8'h3C);
    up_q.push_back(8'h01);
    up_q.push_back(8'h80);
    run_cycles(6 * FRAME + 20);

    $display("[TB] pulls into an empty upstream FIFO");
    run_cycles(10);
    checkOutput("pull_held", 32'(DIPULL), 32'd1);

    $display("[TB] forced pushes past the credit limit");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, BW'($urandom));
    run_cycles(6 * FRAME + 10);
    checkOutput("ovf_sticky", 32'(OVF), 32'd1);

    $display("[TB] reset in the middle of a 0x0F frame");
    up_q.push_back(8'h0F);
    run_cycles(20);
    #2;
    RSTX = 1'b0;
    #1;
    checkOutput("rst_txd", 32'(TXD), 32'd1);
    checkOutput("rst_pull", 32'(DIPULL), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_ovf", 32'(OVF), 32'd0);
    do_reset();
    up_q.push_back(8'hC3);
    run_cycles(FRAME + 10);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 5) == 0) && (up_q.size() < 8)) up_q.push_back(BW'($urandom));
      applyStimulus(1'b0, 1'b0, '0);
    end
    run_cycles(14 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
